// File: rtl/uart_loader.sv
// uart_loader: 8N1 UART receiver that assembles {command, hi, lo} packets into 16-bit load words.
// Define UART_LOADER_CHECKSUM_EN to require a trailing cmd^hi^lo checksum byte in every packet.
module uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        uart_en,
  output logic [1:0]  uart_sel,
  output logic [15:0] uart_data,
  output logic        busy,
  output logic        frame_err,
  output logic        cmd_err,
  output logic [15:0] word_count
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

  localparam logic [7:0] CMD_INSTR = 8'h49;
  localparam logic [7:0] CMD_DATA  = 8'h4D;
  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_DATA  = 2'd1;
  localparam logic [1:0] SEL_INSTR = 2'd2;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rxState_t;

`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    P_CMD = 2'd0,
    P_HI  = 2'd1,
    P_LO  = 2'd2,
    P_SUM = 2'd3
  } pktState_t;

  function automatic logic [7:0] packetSum(input logic [7:0] c, input logic [7:0] h,
                                           input logic [7:0] l);
    return c ^ h ^ l;
  endfunction
`else
  typedef enum logic [1:0] {
    P_CMD = 2'd0,
    P_HI  = 2'd1,
    P_LO  = 2'd2
  } pktState_t;
`endif

  logic             rxMeta_r, rxSync_r, rxPrev_r;
  rxState_t         rxState_r, rxStateNext_s;
  logic [CNT_W-1:0] clkCnt_r, clkCntNext_s;
  logic [2:0]       bitIdx_r, bitIdxNext_s;
  logic [7:0]       shift_r, shiftNext_s;
  logic             byteValid_s, frameErr_s;

  pktState_t        pState_r, pStateNext_s;
  logic [1:0]       pktSel_r, pktSelNext_s;
  logic [7:0]       hi_r, hiNext_s;
  logic [7:0]       lo_r, loNext_s;
  logic [TO_W-1:0]  toCnt_r, toCntNext_s;
  logic             timeout_s, deliver_s, cmdErr_s;
  logic [15:0]      deliverData_s;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]       cmdByte_r, cmdByteNext_s;
`endif

  // Synchronize rx; rxPrev_r keeps the prior synchronized sample for falling-edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxMeta_r <= 1'b1;
      rxSync_r <= 1'b1;
      rxPrev_r <= 1'b1;
    end else begin
      rxMeta_r <= rx;
      rxSync_r <= rxMeta_r;
      rxPrev_r <= rxSync_r;
    end
  end

  // Bit receiver next-state: mid-bit sampling, LSB first
  always_comb begin
    rxStateNext_s = rxState_r;
    clkCntNext_s  = clkCnt_r;
    bitIdxNext_s  = bitIdx_r;
    shiftNext_s   = shift_r;
    byteValid_s   = 1'b0;
    frameErr_s    = 1'b0;
    case (rxState_r)
      RX_IDLE: begin
        clkCntNext_s = {CNT_W{1'b0}};
        if (rxPrev_r && !rxSync_r) begin
          rxStateNext_s = RX_START;
          bitIdxNext_s  = 3'd0;
        end else begin
          rxStateNext_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (clkCnt_r == HALF_LAST) begin
          clkCntNext_s  = {CNT_W{1'b0}};
          rxStateNext_s = rxSync_r ? RX_IDLE : RX_DATA;
        end else begin
          clkCntNext_s = clkCnt_r + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (clkCnt_r == BIT_LAST) begin
          clkCntNext_s = {CNT_W{1'b0}};
          shiftNext_s  = {rxSync_r, shift_r[7:1]};
          if (bitIdx_r == 3'd7) begin
            rxStateNext_s = RX_STOP;
          end else begin
            bitIdxNext_s = bitIdx_r + 3'd1;
          end
        end else begin
          clkCntNext_s = clkCnt_r + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (clkCnt_r == BIT_LAST) begin
          clkCntNext_s  = {CNT_W{1'b0}};
          rxStateNext_s = RX_IDLE;
          if (rxSync_r) begin
            byteValid_s = 1'b1;
          end else begin
            frameErr_s = 1'b1;
          end
        end else begin
          clkCntNext_s = clkCnt_r + CNT_W'(1);
        end
      end
      default: begin
        rxStateNext_s = RX_IDLE;
        clkCntNext_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  // Bit receiver state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxState_r <= RX_IDLE;
      clkCnt_r  <= {CNT_W{1'b0}};
      bitIdx_r  <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      rxState_r <= rxStateNext_s;
      clkCnt_r  <= clkCntNext_s;
      bitIdx_r  <= bitIdxNext_s;
      shift_r   <= shiftNext_s;
    end
  end

  // Packet next-state; the idle timer only advances while the line is between bytes
  always_comb begin
    pStateNext_s  = pState_r;
    pktSelNext_s  = pktSel_r;
    hiNext_s      = hi_r;
    loNext_s      = lo_r;
    deliver_s     = 1'b0;
    cmdErr_s      = 1'b0;
    deliverData_s = {hi_r, lo_r};
`ifdef UART_LOADER_CHECKSUM_EN
    cmdByteNext_s = cmdByte_r;
`endif
    if ((pState_r == P_CMD) || byteValid_s) begin
      toCntNext_s = {TO_W{1'b0}};
    end else if (rxState_r == RX_IDLE) begin
      toCntNext_s = toCnt_r + TO_W'(1);
    end else begin
      toCntNext_s = toCnt_r;
    end
    timeout_s = (rxState_r == RX_IDLE) && (toCnt_r == TO_LAST);

    case (pState_r)
      P_CMD: begin
        if (byteValid_s) begin
`ifdef UART_LOADER_CHECKSUM_EN
          cmdByteNext_s = shift_r;
`endif
          if (shift_r == CMD_INSTR) begin
            pktSelNext_s = SEL_INSTR;
            pStateNext_s = P_HI;
          end else if (shift_r == CMD_DATA) begin
            pktSelNext_s = SEL_DATA;
            pStateNext_s = P_HI;
          end else begin
            cmdErr_s     = 1'b1;
            pStateNext_s = P_CMD;
          end
        end else begin
          pStateNext_s = P_CMD;
        end
      end
      P_HI: begin
        if (frameErr_s || timeout_s) begin
          pStateNext_s = P_CMD;
        end else if (byteValid_s) begin
          hiNext_s     = shift_r;
          pStateNext_s = P_LO;
        end else begin
          pStateNext_s = P_HI;
        end
      end
      P_LO: begin
        if (frameErr_s || timeout_s) begin
          pStateNext_s = P_CMD;
        end else if (byteValid_s) begin
          loNext_s = shift_r;
`ifdef UART_LOADER_CHECKSUM_EN
          pStateNext_s = P_SUM;
`else
          deliver_s     = 1'b1;
          deliverData_s = {hi_r, shift_r};
          pStateNext_s  = P_CMD;
`endif
        end else begin
          pStateNext_s = P_LO;
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      P_SUM: begin
        if (frameErr_s || timeout_s) begin
          pStateNext_s = P_CMD;
        end else if (byteValid_s) begin
          pStateNext_s = P_CMD;
          if (shift_r == packetSum(cmdByte_r, hi_r, lo_r)) begin
            deliver_s = 1'b1;
          end else begin
            cmdErr_s = 1'b1;
          end
        end else begin
          pStateNext_s = P_SUM;
        end
      end
`endif
      default: begin
        pStateNext_s = P_CMD;
      end
    endcase
  end

  // Packet state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      pState_r <= P_CMD;
      pktSel_r <= SEL_NONE;
      hi_r     <= 8'h00;
      lo_r     <= 8'h00;
      toCnt_r  <= {TO_W{1'b0}};
`ifdef UART_LOADER_CHECKSUM_EN
      cmdByte_r <= 8'h00;
`endif
    end else begin
      pState_r <= pStateNext_s;
      pktSel_r <= pktSelNext_s;
      hi_r     <= hiNext_s;
      lo_r     <= loNext_s;
      toCnt_r  <= toCntNext_s;
`ifdef UART_LOADER_CHECKSUM_EN
      cmdByte_r <= cmdByteNext_s;
`endif
    end
  end

  // Registered outputs; sel/data only change on a successful delivery
  always_ff @(posedge clk) begin
    if (!reset) begin
      uart_en    <= 1'b0;
      uart_sel   <= SEL_NONE;
      uart_data  <= 16'h0000;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      cmd_err    <= 1'b0;
      word_count <= 16'h0000;
    end else begin
      uart_en   <= deliver_s;
      busy      <= (pStateNext_s != P_CMD);
      frame_err <= frameErr_s;
      cmd_err   <= cmdErr_s;
      if (deliver_s) begin
        uart_sel   <= pktSel_r;
        uart_data  <= deliverData_s;
        word_count <= word_count + 16'd1;
      end else begin
        uart_sel   <= uart_sel;
        uart_data  <= uart_data;
        word_count <= word_count;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: vector table of packets plus hand-written error/timeout/reset sequences.
// A negedge monitor pops expected words from a scoreboard queue on every uart_en strobe.
module tb_uart_loader;

  localparam int CPB = 16;

  logic        clk;
  logic        reset;
  logic        rx;
  logic        uart_en;
  logic [1:0]  uart_sel;
  logic [15:0] uart_data;
  logic        busy;
  logic        frame_err;
  logic        cmd_err;
  logic [15:0] word_count;

  uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(32)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .uart_en(uart_en), .uart_sel(uart_sel), .uart_data(uart_data),
    .busy(busy), .frame_err(frame_err), .cmd_err(cmd_err), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [1:0]  sel;
    logic [15:0] data;
  } vec_t;

  exp_t        expQ[$];
  exp_t        e;
  vec_t        vecs[6];
  int          checks = 0;
  int          failures = 0;
  int          cmdErrCnt = 0;
  int          frameErrCnt = 0;
  int          c0, f0;
  logic [15:0] expWc = 16'd0;
  logic        prevCmdErr = 1'b0;
  logic        prevFrameErr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic bitTime(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idleBits(input int n);
    for (int i = 0; i < n; i++) bitTime(1'b1);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    bitTime(1'b0);
    for (int i = 0; i < 8; i++) bitTime(b[i]);
    bitTime(stopBit);
  endtask

  task automatic sendPkt(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                         input logic [1:0] sel, input logic [15:0] data);
    expQ.push_back({sel, data});
    sendByte(c, 1'b1);
    sendByte(h, 1'b1);
    sendByte(l, 1'b1);
`ifdef UART_LOADER_CHECKSUM_EN
    sendByte(c ^ h ^ l, 1'b1);
`endif
  endtask

  // Scoreboard monitor and error-pulse width checks
  always @(negedge clk) begin
    if (reset) begin
      if (uart_en) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe actual sel=%0d data=%h expected no strobe", uart_sel, uart_data);
        end else begin
          e = expQ.pop_front();
          expWc = expWc + 16'd1;
          if (uart_sel !== e.sel || uart_data !== e.data || word_count !== expWc) begin
            failures++;
            $display("FAIL strobe actual sel=%0d data=%h count=%0d expected sel=%0d data=%h count=%0d",
                     uart_sel, uart_data, word_count, e.sel, e.data, expWc);
          end
        end
      end
      if (cmd_err) begin
        cmdErrCnt++;
        checks++;
        if (prevCmdErr) begin
          failures++;
          $display("FAIL cmd_err_width actual=2+ cycles expected=1 cycle");
        end
      end
      if (frame_err) begin
        frameErrCnt++;
        checks++;
        if (prevFrameErr) begin
          failures++;
          $display("FAIL frame_err_width actual=2+ cycles expected=1 cycle");
        end
      end
    end
    prevCmdErr   = cmd_err;
    prevFrameErr = frame_err;
  end

  initial begin
    vecs[0] = '{8'h49, 8'h12, 8'h34, 2'd2, 16'h1234};
    vecs[1] = '{8'h4D, 8'hAB, 8'hCD, 2'd1, 16'hABCD};
    vecs[2] = '{8'h49, 8'h00, 8'h01, 2'd2, 16'h0001};
    vecs[3] = '{8'h4D, 8'hFF, 8'hFF, 2'd1, 16'hFFFF};
    vecs[4] = '{8'h4D, 8'h00, 8'h00, 2'd1, 16'h0000};
    vecs[5] = '{8'h49, 8'h80, 8'h7E, 2'd2, 16'h807E};

    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uart_en", 32'(uart_en), 32'd0);
    check("rst_uart_sel", 32'(uart_sel), 32'd0);
    check("rst_uart_data", 32'(uart_data), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    reset = 1'b1;
    idleBits(2);

    // Table of valid packets, sent back-to-back
    for (int i = 0; i < 6; i++) begin
      expQ.push_back({vecs[i].sel, vecs[i].data});
      sendByte(vecs[i].cmd, 1'b1);
      check("busy_after_cmd", 32'(busy), 32'd1);
      sendByte(vecs[i].hi, 1'b1);
      sendByte(vecs[i].lo, 1'b1);
`ifdef UART_LOADER_CHECKSUM_EN
      sendByte(vecs[i].cmd ^ vecs[i].hi ^ vecs[i].lo, 1'b1);
`endif
      check("vec_sel", 32'(uart_sel), 32'(vecs[i].sel));
      check("vec_data", 32'(uart_data), 32'(vecs[i].data));
      check("vec_count", 32'(word_count), 32'(i + 1));
      check("vec_busy", 32'(busy), 32'd0);
    end

    // Unknown command byte, then a good packet
    c0 = cmdErrCnt;
    sendByte(8'h55, 1'b1);
    check("badcmd_err", 32'(cmdErrCnt - c0), 32'd1);
    check("badcmd_busy", 32'(busy), 32'd0);
    check("badcmd_count", 32'(word_count), 32'd6);
    sendPkt(8'h49, 8'hBE, 8'hEF, 2'd2, 16'hBEEF);
    check("beef_data", 32'(uart_data), 32'hBEEF);
    check("beef_count", 32'(word_count), 32'd7);

    // Framing error on the low byte aborts the packet
    f0 = frameErrCnt;
    sendByte(8'h49, 1'b1);
    sendByte(8'h12, 1'b1);
    sendByte(8'h34, 1'b0);
    bitTime(1'b1);
    check("frame_err_pulse", 32'(frameErrCnt - f0), 32'd1);
    check("frame_busy", 32'(busy), 32'd0);
    check("frame_data_held", 32'(uart_data), 32'hBEEF);
    check("frame_count", 32'(word_count), 32'd7);

    // Short low glitch is rejected silently
    c0 = cmdErrCnt;
    f0 = frameErrCnt;
    rx = 1'b0;
    repeat (CPB / 2 - 1) @(negedge clk);
    idleBits(2);
    check("glitch_frame", 32'(frameErrCnt - f0), 32'd0);
    check("glitch_cmd", 32'(cmdErrCnt - c0), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);

    // Inter-byte timeout aborts silently; trailing byte is then an unknown command
    sendByte(8'h4D, 1'b1);
    sendByte(8'h11, 1'b1);
    check("timeout_busy_before", 32'(busy), 32'd1);
    idleBits(33);
    check("timeout_busy_after", 32'(busy), 32'd0);
    check("timeout_no_err", 32'(cmdErrCnt - c0), 32'd0);
    sendByte(8'h22, 1'b1);
    check("timeout_cmd_err", 32'(cmdErrCnt - c0), 32'd1);
    check("timeout_count", 32'(word_count), 32'd7);
    check("timeout_data_held", 32'(uart_data), 32'hBEEF);

`ifdef UART_LOADER_CHECKSUM_EN
    expQ.push_back({2'd2, 16'h1234});
    sendByte(8'h49, 1'b1);
    sendByte(8'h12, 1'b1);
    sendByte(8'h34, 1'b1);
    sendByte(8'h6F, 1'b1);
    check("sum_ok_data", 32'(uart_data), 32'h1234);
    check("sum_ok_count", 32'(word_count), 32'd8);
    c0 = cmdErrCnt;
    sendByte(8'h49, 1'b1);
    sendByte(8'hAA, 1'b1);
    sendByte(8'h55, 1'b1);
    sendByte(8'h00, 1'b1);
    check("sum_bad_err", 32'(cmdErrCnt - c0), 32'd1);
    check("sum_bad_count", 32'(word_count), 32'd8);
    check("sum_bad_data", 32'(uart_data), 32'h1234);
`endif

    // Reset in the middle of a packet and a byte
    sendPkt(8'h4D, 8'h5A, 8'hA5, 2'd1, 16'h5AA5);
    sendByte(8'h49, 1'b1);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("midreset_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_uart_en", 32'(uart_en), 32'd0);
    check("midreset_sel", 32'(uart_sel), 32'd0);
    check("midreset_data", 32'(uart_data), 32'h0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    check("midreset_cmd_err", 32'(cmd_err), 32'd0);
    check("midreset_count", 32'(word_count), 32'd0);
    expWc = 16'd0;
    expQ.delete();
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    idleBits(2);
    sendPkt(8'h49, 8'h00, 8'h7F, 2'd2, 16'h007F);
    check("post_reset_count", 32'(word_count), 32'd1);
    check("post_reset_data", 32'(uart_data), 32'h007F);
    idleBits(2);

    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
